// File: rtl/sort_result_collector.sv
// Frame buffer behind a serial sorter: collects N signed words, checks that they
// arrived in ascending order, then replays them downstream with a valid/ready handshake.
module sort_result_collector #(
    parameter int WIDTH = 32,
    parameter int N     = 10,
    localparam int CW   = $clog2(N + 1),
    localparam int IW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             sorted_ok_o,
    output logic             frame_done_o,
    output logic [CW-1:0]    count_o
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            wr_idx_q, wr_idx_d;
    logic [IW-1:0]            rd_idx_q, rd_idx_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     err_q, err_d;
    logic signed [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    logic                     frame_done_q, frame_done_d;
    logic [WIDTH-1:0]         buffer_q [N];

    logic          in_accept;
    logic          out_accept;
    logic          wr_last;
    logic          rd_last;
    logic [IW-1:0] rd_idx_inc;

    assign in_accept  = (state_q == FILL) && in_valid_i;
    assign out_accept = (state_q == DRAIN) && out_ready_i;
    assign wr_last    = (wr_idx_q == IW'(N - 1));
    assign rd_last    = (rd_idx_q == IW'(N - 1));
    assign rd_idx_inc = rd_idx_q + IW'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_accept && wr_last)  state_d = DRAIN;
            DRAIN:   if (out_accept && rd_last) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == FILL);
        out_valid_o = (state_q == DRAIN);
        out_last_o  = (state_q == DRAIN) && rd_last;
        sorted_ok_o = (state_q == DRAIN) && !err_q;
    end

    // Datapath next-state: write side, order check and registered read port.
    always_comb begin
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        count_d      = count_q;
        err_d        = err_q;
        prev_d       = prev_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        if (in_accept) begin
            wr_idx_d = wr_last ? '0 : wr_idx_q + IW'(1);
            count_d  = count_q + CW'(1);
            prev_d   = $signed(in_data_i);
            if (wr_idx_q == '0) begin
                err_d = 1'b0;
            end else if ($signed(in_data_i) < prev_q) begin
                err_d = 1'b1;
            end
            // Word 0 is already stored, so it can be presented on the DRAIN entry edge.
            if (wr_last) begin
                out_data_d = buffer_q[0];
            end
        end

        if (out_accept) begin
            if (rd_last) begin
                rd_idx_d     = '0;
                count_d      = '0;
                out_data_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                rd_idx_d   = rd_idx_inc;
                count_d    = count_q - CW'(1);
                out_data_d = buffer_q[rd_idx_inc];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            prev_q       <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            count_q      <= count_d;
            err_q        <= err_d;
            prev_q       <= prev_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the frame buffer has no reset; stale words are never read because
    // the indices and state restart cleanly, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            buffer_q[wr_idx_q] <= in_data_i;
        end
    end

    assign out_data_o   = out_data_q;
    assign frame_done_o = frame_done_q;
    assign count_o      = count_q;

endmodule

// File: doc/sort_result_collector.md
SORT_RESULT_COLLECTOR -- requirements
Module: sort_result_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 32: signed data word width.
REQ-002 SHALL have parameter N, default 10: words per frame; N >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data_i  input  WIDTH  signed word from the serial sorter output.
REQ-006 SHALL have port in_valid_i  input  1  in_data_i valid this cycle.
REQ-007 SHALL have port in_ready_o  output  1  collector accepts a word this cycle.
REQ-008 SHALL have port out_data_o  output  WIDTH  buffered word presented downstream.
REQ-009 SHALL have port out_valid_o  output  1  out_data_o valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream accepts out_data_o.
REQ-011 SHALL have port out_last_o  output  1  current output word is word N-1 of the frame.
REQ-012 SHALL have port sorted_ok_o  output  1  frame checked ascending; valid while out_valid_o=1.
REQ-013 SHALL have port frame_done_o  output  1  one-cycle pulse after the last output transfer.
REQ-014 SHALL have port count_o  output  ceil(log2(N+1))  words currently held in the buffer.

Function
REQ-015 SHALL implement a two-state FSM, FILL and DRAIN, plus an N x WIDTH buffer, write index and read index.
REQ-016 In FILL, in_ready_o SHALL be 1; in DRAIN, in_ready_o SHALL be 0.
REQ-017 Input transfer SHALL occur on a clk edge with in_valid_i=1 and in_ready_o=1; the word is stored at the write index, and the write index and count_o increment by 1.
REQ-018 in_valid_i=1 in DRAIN SHALL be ignored: no buffer write, no state change.
REQ-019 Each accepted word after the first of a frame SHALL be compared, signed, with the previously accepted word; if new < previous, a sticky order-error flag SHALL set.
REQ-020 Equal adjacent words SHALL NOT set the order-error flag.
REQ-021 Accepting the first word of a frame SHALL clear the order-error flag.
REQ-022 The transfer that accepts word N-1 SHALL move FILL -> DRAIN on the same edge; the write index SHALL wrap to 0.
REQ-023 In DRAIN, out_valid_o SHALL be 1 and out_data_o SHALL equal buffer[read index], registered; the first word is visible the cycle after the transition.
REQ-024 In FILL, out_valid_o SHALL be 0 and out_last_o SHALL be 0.
REQ-025 Output transfer SHALL occur on a clk edge with out_valid_o=1 and out_ready_i=1; the read index increments and count_o decrements by 1.
REQ-026 out_data_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-027 out_last_o SHALL be 1 exactly when the read index equals N-1 in DRAIN.
REQ-028 sorted_ok_o SHALL equal NOT order-error flag in DRAIN, and 0 in FILL.
REQ-029 The transfer of word N-1 SHALL move DRAIN -> FILL, wrap the read index to 0, set count_o to 0, and assert frame_done_o for exactly the next cycle.
REQ-030 in_ready_o SHALL return to 1 the cycle after the final output transfer; no input is accepted on the same edge as that transfer.
REQ-031 Minimum frame latency SHALL be N input cycles plus N output cycles; no bubbles when both valids and readies are held high.

Reset
REQ-032 rst=1 SHALL asynchronously force FILL, both indices 0, count_o=0, and the order-error flag to 0.
REQ-033 During and after reset, outputs SHALL be in_ready_o=1, out_valid_o=0, out_last_o=0, sorted_ok_o=0, frame_done_o=0, out_data_o=0.
REQ-034 Buffer contents need not reset; rst asserted mid-FILL or mid-DRAIN SHALL discard the partial frame.

Verification
REQ-035 Input 1..10 back-to-back with out_ready_i=1 -> out_data_o 1..10 in order, sorted_ok_o=1, out_last_o on value 10, and one frame_done_o pulse.
REQ-036 Input 5,3,-7,0,2,2,9,-1,4,8 -> sorted_ok_o=0 throughout DRAIN, and the output order matches the input.
REQ-037 Input -10,-9,...,-1 -> sorted_ok_o=1, which confirms signed compare; a frame containing 32'h8000_0000 followed by 0 -> sorted_ok_o=1.
REQ-038 out_ready_i toggling 1,0,0,1 in DRAIN -> out_data_o stable across the stalls, count_o decrements only on transfers, and in_valid_i=1 pulses in DRAIN are ignored.
REQ-039 rst pulse after 6 words accepted -> count_o=0, FILL; the next 10 words form a complete fresh frame with a correct sorted_ok_o.
REQ-040 Two frames back-to-back with 7 7 duplicates in the second -> the second frame reports sorted_ok_o=1, and the error flag from a bad first frame does not carry over.
